// File: rtl/rcn_pkg.sv
// Shared RCN ring slot layout and register offsets for ring responders.
package rcn_pkg;

    localparam int SLOT_W  = 69;
    localparam int DATA_W  = 32;

    localparam int VALID_B = 68;
    localparam int PEND_B  = 67;
    localparam int WR_B    = 66;
    localparam int ID_HI   = 65;
    localparam int ID_LO   = 60;
    localparam int MASK_HI = 59;
    localparam int MASK_LO = 56;
    localparam int ADDR_HI = 55;
    localparam int ADDR_LO = 34;
    localparam int SEQ_HI  = 33;
    localparam int SEQ_LO  = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    localparam logic [2:0] OFS_PROGRESS = 3'd0;
    localparam logic [2:0] OFS_PASS     = 3'd1;
    localparam logic [2:0] OFS_FAIL     = 3'd2;
    localparam logic [2:0] OFS_CYCLES   = 3'd3;
    localparam logic [2:0] OFS_SCRATCH  = 3'd4;
    localparam logic [2:0] OFS_ID       = 3'd5;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [3:0]        mask
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) res[8*n +: 8] = new_val[8*n +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rcn_slot_decode.sv
// Combinational RCN slot unpacking with window hit and register offset.
module rcn_slot_decode
    import rcn_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = 24'hFFFF00,
    parameter logic [23:0] ADDR_MASK = 24'hFFFFE0
) (
    input  logic [SLOT_W-1:0] slot,
    output logic              valid,
    output logic              wr,
    output logic [5:0]        id,
    output logic [3:0]        mask,
    output logic [21:0]       addr,
    output logic [1:0]        seq,
    output logic [DATA_W-1:0] data,
    output logic              hit,
    output logic [2:0]        ofs
);

    logic        pending;
    logic [23:0] byte_addr;

    always_comb begin
        valid     = slot[VALID_B];
        pending   = slot[PEND_B];
        wr        = slot[WR_B];
        id        = slot[ID_HI:ID_LO];
        mask      = slot[MASK_HI:MASK_LO];
        addr      = slot[ADDR_HI:ADDR_LO];
        seq       = slot[SEQ_HI:SEQ_LO];
        data      = slot[DATA_HI:DATA_LO];
        byte_addr = {addr, 2'b00};
        // Only pending requests can hit; responses and idle slots flow past.
        hit       = valid && pending && ((byte_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
        ofs       = addr[2:0];
    end

endmodule

// File: rtl/rcn_sim_status.sv
// RCN responder exposing firmware-writable simulation status, a cycle
// counter, a scratch register and a read-only block ID.
module rcn_sim_status
    import rcn_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = 24'hFFFF00,
    parameter logic [23:0] ADDR_MASK = 24'hFFFFE0,
    parameter logic [31:0] BLOCK_ID  = 32'h5354_4154
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W-1:0] rcn_in,
    output logic [SLOT_W-1:0] rcn_out,
    output logic [31:0]       test_progress,
    output logic [31:0]       test_pass,
    output logic [31:0]       test_fail,
    output logic              test_done
);

    logic              in_valid;
    logic              in_wr;
    logic [5:0]        in_id;
    logic [3:0]        in_mask;
    logic [21:0]       in_addr;
    logic [1:0]        in_seq;
    logic [DATA_W-1:0] in_data;
    logic              in_hit;
    logic [2:0]        in_ofs;

    rcn_slot_decode #(
        .ADDR_BASE (ADDR_BASE),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .slot  (rcn_in),
        .valid (in_valid),
        .wr    (in_wr),
        .id    (in_id),
        .mask  (in_mask),
        .addr  (in_addr),
        .seq   (in_seq),
        .data  (in_data),
        .hit   (in_hit),
        .ofs   (in_ofs)
    );

    logic [SLOT_W-1:0] rcn_out_q,  rcn_out_d;
    logic [31:0]       progress_q, progress_d;
    logic [31:0]       pass_q,     pass_d;
    logic [31:0]       fail_q,     fail_d;
    logic [31:0]       cycles_q,   cycles_d;
    logic [31:0]       scratch_q,  scratch_d;
    logic              done_q,     done_d;
    logic [31:0]       rd_data;

    always_comb begin
        rcn_out_d  = rcn_in;
        progress_d = progress_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        cycles_d   = cycles_q + 32'd1;
        scratch_d  = scratch_q;
        done_d     = 1'b0;
        rd_data    = '0;

        case (in_ofs)
            OFS_PROGRESS: rd_data = progress_q;
            OFS_PASS:     rd_data = pass_q;
            OFS_FAIL:     rd_data = fail_q;
            OFS_CYCLES:   rd_data = cycles_q;
            OFS_SCRATCH:  rd_data = scratch_q;
            OFS_ID:       rd_data = BLOCK_ID;
            default:      rd_data = '0;
        endcase

        if (in_hit) begin
            if (in_wr) begin
                case (in_ofs)
                    OFS_PROGRESS: progress_d = merge_bytes(progress_q, in_data, in_mask);
                    // PASS/FAIL lock once nonzero; a write leaving them zero keeps them open.
                    OFS_PASS: begin
                        if (pass_q == '0) begin
                            pass_d = merge_bytes(pass_q, in_data, in_mask);
                            done_d = (pass_d != '0);
                        end
                    end
                    OFS_FAIL: begin
                        if (fail_q == '0) begin
                            fail_d = merge_bytes(fail_q, in_data, in_mask);
                            done_d = (fail_d != '0);
                        end
                    end
                    OFS_CYCLES: begin
                        if (in_mask != 4'b0000) cycles_d = '0;
                    end
                    OFS_SCRATCH:  scratch_d = merge_bytes(scratch_q, in_data, in_mask);
                    default:      ;
                endcase
            end
            rcn_out_d = {in_valid, 1'b0, in_wr, in_id, in_mask, in_addr, in_seq,
                         in_wr ? in_data : rd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcn_out_q  <= '0;
            progress_q <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            cycles_q   <= '0;
            scratch_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            rcn_out_q  <= rcn_out_d;
            progress_q <= progress_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            cycles_q   <= cycles_d;
            scratch_q  <= scratch_d;
            done_q     <= done_d;
        end
    end

    assign rcn_out       = rcn_out_q;
    assign test_progress = progress_q;
    assign test_pass     = pass_q;
    assign test_fail     = fail_q;
    assign test_done     = done_q;

endmodule

// File: doc/rcn_sim_status.md
Name: rcn_sim_status

Overview:
- RCN ring responder that gives firmware the writable side of simulation status.
- Firmware writes progress, pass and fail codes; the devkit testbench samples the resulting status outputs hierarchically to log progress and end the run.
- Also provides a free-running cycle counter, a scratch register and a read-only ID.
- Sits on the RCN ring inside max10_devkit_top in place of the legacy test-register slave.

Parameters:
- ADDR_BASE, 24'hFFFF00: byte base address of the 32-byte register window.
- ADDR_MASK, 24'hFFFFE0: byte address bits compared for a window hit.
- BLOCK_ID, 32'h5354_4154: value returned by the ID register.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rcn_in  in  69  ring input slot.
- rcn_out  out  69  ring output slot, registered.
- test_progress  out  32  progress register value.
- test_pass  out  32  pass code; nonzero means pass.
- test_fail  out  32  fail code; nonzero means fail.
- test_done  out  1  one-cycle pulse on the first nonzero write to pass or fail.

Behaviour:
- RCN slot format, bit 68 down to bit 0:
  - valid[68], pending[67], wr[66], id[65:60], mask[59:56], addr[55:34] (byte address bits 23:2), seq[33:32], data[31:0].
- Hit condition: valid && pending && ((addr << 2) & ADDR_MASK) == (ADDR_BASE & ADDR_MASK). Register offset = addr[2:0].
- Latency: every slot is registered, so rcn_out equals the processed rcn_in one cycle later.
  - A non-hit slot passes through unchanged, including invalid slots and responses.
- Response to a hit:
  - Same slot, pending=0.
  - valid, wr, id, mask, addr and seq copied from the request.
  - Read: data = selected register value.
  - Write: data = request data echoed back.
- Write byte lanes: mask[n] enables data[8n+7:8n]. mask=0 is a legal no-op write that still gets a response.
- Register map (offset: register):
  - 0: PROGRESS. RW, reset 0.
  - 1: PASS. RW, reset 0. Sticky: once the stored value is nonzero, further writes are ignored until rst.
  - 2: FAIL. Same sticky rule as PASS.
  - 3: CYCLES. Reset 0, +1 every clk, wraps 32'hFFFFFFFF -> 0.
    - Any write with a nonzero mask sets it to 0 that cycle; the counter does not also increment that cycle.
    - A read returns the pre-increment value of the cycle in which the hit is registered.
  - 4: SCRATCH. RW, reset 0.
  - 5: ID. RO, returns BLOCK_ID; writes ignored.
  - 6, 7: read 0; writes ignored; still respond.
- Reset values: rcn_out=0 (invalid slot); test_progress, test_pass, test_fail and CYCLES = 0; test_done=0.
- Status outputs update the cycle after the write hit, at the same edge as the response.
- test_done asserts for exactly one cycle when PASS or FAIL goes from zero to nonzero.
  - It does not assert again after that.
  - A write of 0 to a zero PASS does not count.
- A byte-masked write that leaves PASS or FAIL zero keeps it unlocked.
- Back-to-back hits on consecutive cycles are all serviced; there is no backpressure.
- rst asserted mid-transaction: the slot being registered is dropped (rcn_out=0). The initiator's timeout or retry handles the loss.

Decomposition:
- Package rcn_pkg holds:
  - slot width (69);
  - field bit positions;
  - register offset constants (OFS_PROGRESS..OFS_ID).
- One sub-module, rcn_slot_decode: combinational field unpacking and hit/offset generation, reusable by other RCN responders.
- Register file and the slot output register stay in rcn_sim_status.

Test Plan:
- Reset, then read offsets 0-5. Expected: data 0,0,0,(cycle count),0,32'h53544154. Responses appear one cycle after request, pending=0, id and seq preserved.
- Write PROGRESS 32'h0000_0012 with mask 4'b0011, then with mask 4'b1100 data 32'hAB00_0000. Expected: test_progress = 32'hAB00_0012; each write response echoes its own data.
- Write PASS 32'h1 with mask 4'b1111. Expected: test_done pulses once; test_pass=1. A second PASS write of 32'h7 leaves test_pass=1 with no pulse.
- Write FAIL 0, then 32'hDEAD. Expected: test_done only on the second write; test_fail=32'hDEAD.
- Write CYCLES, wait 10 cycles, read. Expected: value 10 relative to the clear edge.
  - Force counter to 32'hFFFFFFFF and step one clock. Expected: wraps to 0.
- Inject a non-hit request, a response slot and an invalid slot interleaved with hits on consecutive cycles. Expected: non-hits are bit-identical one cycle later and all hits are answered. Asserting rst mid-stream gives rcn_out=0 and every register reset.
